// File: rtl/char_rx_packer_pkg.sv
// -----------------------------------------------------------------------------
// char_rx_packer_pkg
// Purpose : Shared definitions for the UDP byte-stream to 32-bit word packer.
//           Holds the FSM state encoding, default header constants, the bit
//           positions inside err_flags and the helper that left-aligns a
//           partially filled word.
// -----------------------------------------------------------------------------
package char_rx_packer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_PAD     = 3'd3,
    ST_DROP    = 3'd4
  } state_t;

  localparam int          MAX_WORDS_DEF = 2048;
  localparam logic [15:0] MAGIC_DEF     = 16'hA55A;

  localparam int ERR_LEN   = 2;
  localparam int ERR_SHORT = 1;
  localparam int ERR_LONG  = 0;

  // The shift register holds the most recent bytes in its low lanes. When a
  // frame ends mid-word, move the received bytes to the top and fill the
  // unused low lanes with zeros so the first byte still lands in [31:24].
  // idx is the lane index of the byte just received (0 = first byte).
  function automatic logic [31:0] align_word(input logic [31:0] w,
                                             input logic [1:0]  idx);
    logic [31:0] r;
    case (idx)
      2'd0:    r = {w[7:0],  24'h0};
      2'd1:    r = {w[15:0], 16'h0};
      2'd2:    r = {w[23:0], 8'h0};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/char_rx_packer.sv
// -----------------------------------------------------------------------------
// char_rx_packer
// Purpose : Validates a 4-byte frame header (MAGIC, LEN) on the UDP byte stream
//           and packs the payload big-endian into 32-bit words for the
//           character-overlay bitmap RAM. Exactly LEN words are emitted per
//           accepted frame; short frames are zero-padded so the downstream
//           free-running write address stays row-aligned.
// Ports   :
//   udp_clk    in   sole clock
//   rstn       in   asynchronous active-low reset
//   rx_valid   in   byte valid
//   rx_data    in   [7:0] byte
//   rx_sop     in   first byte of a UDP payload (qualified by rx_valid)
//   rx_eop     in   last byte of a UDP payload (qualified by rx_valid)
//   rx_ready   out  byte accepted when rx_valid && rx_ready
//   rec_en     out  word write strobe
//   rec_data   out  [31:0] packed word
//   frame_done out  pulse with the last word (data or pad) of a frame
//   err_flags  out  [2:0] sticky {len_err, short_err, long_err}
//   dbg_state  out  current FSM state, for observation only
//
// Handshake: a byte transfers on a rising edge where rx_valid && rx_ready.
// rx_ready is registered and never depends on rx_valid; rx_sop/rx_eop/rx_data
// are only meaningful on a transferring cycle.
// -----------------------------------------------------------------------------
module char_rx_packer
  import char_rx_packer_pkg::*;
#(
  parameter int          MAX_WORDS = MAX_WORDS_DEF,
  parameter logic [15:0] MAGIC     = MAGIC_DEF
) (
  input  logic        udp_clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_sop,
  input  logic        rx_eop,
  output logic        rx_ready,
  output logic        rec_en,
  output logic [31:0] rec_data,
  output logic        frame_done,
  output logic [2:0]  err_flags,
  output state_t      dbg_state
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

  state_t      r_state;
  logic [1:0]  r_hdr_idx;
  logic [1:0]  r_byte_idx;
  logic [15:0] r_len;
  logic [15:0] r_word_cnt;
  logic [31:0] r_shift;
  logic        r_rx_ready;
  logic        r_rec_en;
  logic [31:0] r_rec_data;
  logic        r_frame_done;
  logic [2:0]  r_err;

  logic        w_accept;
  logic [31:0] w_shift;
  logic [15:0] w_cnt_inc;
  logic [15:0] w_len_full;
  logic        w_len_bad;
  state_t      w_sop_state;

  assign w_accept   = rx_valid && r_rx_ready;
  assign w_shift    = {r_shift[23:0], rx_data};
  assign w_cnt_inc  = r_word_cnt + 16'd1;
  assign w_len_full = {r_len[15:8], rx_data};
  assign w_len_bad  = (w_len_full == 16'd0) || (w_len_full > MAX_LEN);
  // Where a start-of-payload byte leads, from any state that can accept one.
  // A single-byte payload cannot hold a header, so sop+eop returns to IDLE.
  assign w_sop_state = rx_eop                    ? ST_IDLE :
                       (rx_data == MAGIC[15:8])  ? ST_HDR  : ST_DROP;

  always_ff @(posedge udp_clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_hdr_idx    <= 2'd0;
      r_byte_idx   <= 2'd0;
      r_len        <= 16'd0;
      r_word_cnt   <= 16'd0;
      r_shift      <= 32'd0;
      r_rx_ready   <= 1'b1;
      r_rec_en     <= 1'b0;
      r_rec_data   <= 32'd0;
      r_frame_done <= 1'b0;
      r_err        <= 3'd0;
    end else begin
      r_rec_en     <= 1'b0;
      r_frame_done <= 1'b0;
      r_rx_ready   <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && rx_sop) begin
            r_state   <= w_sop_state;
            r_hdr_idx <= 2'd1;
          end
        end

        ST_HDR: begin
          if (w_accept) begin
            if (rx_sop) begin
              r_state   <= w_sop_state;
              r_hdr_idx <= 2'd1;
            end else begin
              case (r_hdr_idx)
                2'd1: begin
                  if (rx_data != MAGIC[7:0]) r_state <= rx_eop ? ST_IDLE : ST_DROP;
                  else if (rx_eop)           r_state <= ST_IDLE;
                  r_hdr_idx <= 2'd2;
                end
                2'd2: begin
                  r_len[15:8] <= rx_data;
                  r_hdr_idx   <= 2'd3;
                  if (rx_eop) r_state <= ST_IDLE;
                end
                default: begin
                  r_len      <= w_len_full;
                  r_byte_idx <= 2'd0;
                  r_word_cnt <= 16'd0;
                  if (w_len_bad) r_err[ERR_LEN] <= 1'b1;
                  r_state <= rx_eop    ? ST_IDLE :
                             w_len_bad ? ST_DROP : ST_PAYLOAD;
                end
              endcase
            end
          end
        end

        ST_PAYLOAD: begin
          if (w_accept) begin
            if (rx_sop) begin
              // New frame overrides the current one; the partial word is lost.
              r_err[ERR_SHORT] <= 1'b1;
              r_state          <= w_sop_state;
              r_hdr_idx        <= 2'd1;
            end else begin
              r_shift    <= w_shift;
              r_byte_idx <= r_byte_idx + 2'd1;
              if (r_byte_idx == 2'd3 || rx_eop) begin
                r_rec_en   <= 1'b1;
                r_rec_data <= align_word(w_shift, r_byte_idx);
                r_word_cnt <= w_cnt_inc;
                r_byte_idx <= 2'd0;
                if (w_cnt_inc == r_len) begin
                  r_frame_done <= 1'b1;
                  if (rx_eop) begin
                    r_state <= ST_IDLE;
                    // Ending on a partial last word still means bytes were missing.
                    if (r_byte_idx != 2'd3) r_err[ERR_SHORT] <= 1'b1;
                  end else begin
                    r_err[ERR_LONG] <= 1'b1;
                    r_state         <= ST_DROP;
                  end
                end else if (rx_eop) begin
                  r_err[ERR_SHORT] <= 1'b1;
                  r_state          <= ST_PAD;
                  r_rx_ready       <= 1'b0;
                end
              end
            end
          end
        end

        ST_PAD: begin
          // rx_ready stays low through the final pad word, so it is still low
          // in the cycle that word is presented.
          r_rx_ready <= 1'b0;
          r_rec_en   <= 1'b1;
          r_rec_data <= 32'd0;
          r_word_cnt <= w_cnt_inc;
          if (w_cnt_inc == r_len) begin
            r_frame_done <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end

        ST_DROP: begin
          if (w_accept) begin
            if (rx_sop) begin
              r_state   <= w_sop_state;
              r_hdr_idx <= 2'd1;
            end else if (rx_eop) begin
              r_state <= ST_IDLE;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx_ready   = r_rx_ready;
  assign rec_en     = r_rec_en;
  assign rec_data   = r_rec_data;
  assign frame_done = r_frame_done;
  assign err_flags  = r_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_char_rx_packer.sv
// -----------------------------------------------------------------------------
// tb_char_rx_packer
// Directed bench for char_rx_packer. A negedge monitor records every emitted
// word together with frame_done and rx_ready; the main sequence drives frames
// byte by byte and compares the recorded words against hand-computed values.
// -----------------------------------------------------------------------------
module tb_char_rx_packer;
  import char_rx_packer_pkg::*;

  logic        udp_clk;
  logic        rstn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_sop;
  logic        rx_eop;
  logic        rx_ready;
  logic        rec_en;
  logic [31:0] rec_data;
  logic        frame_done;
  logic [2:0]  err_flags;
  state_t      dbg_state;

  int n_cmp;
  int n_err;

  // {frame_done, rx_ready, rec_data}
  logic [33:0] obs_q[$];

  char_rx_packer dut (
    .udp_clk    (udp_clk),
    .rstn       (rstn),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_sop     (rx_sop),
    .rx_eop     (rx_eop),
    .rx_ready   (rx_ready),
    .rec_en     (rec_en),
    .rec_data   (rec_data),
    .frame_done (frame_done),
    .err_flags  (err_flags),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial udp_clk = 1'b0;
  always #5 udp_clk = ~udp_clk;

  // monitor
  always @(negedge udp_clk) begin
    if (rstn && rec_en) obs_q.push_back({frame_done, rx_ready, rec_data});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic expect_word(input string tag, input logic [31:0] data,
                             input logic fd, input logic rdy);
    logic [33:0] o;
    if (obs_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s observed=<no word> expected=%h", tag, {fd, rdy, data});
    end else begin
      o = obs_q.pop_front();
      chk(tag, 64'(o), 64'({fd, rdy, data}));
    end
  endtask

  // driver: called at a negedge, returns at the negedge after acceptance
  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    int n;
    rx_valid = 1'b1;
    rx_data  = d;
    rx_sop   = s;
    rx_eop   = e;
    n = 0;
    while (!rx_ready && n < 16) begin
      @(negedge udp_clk);
      n++;
    end
    if (n >= 16) chk("rdy_timeout", 64'(rx_ready), 64'd1);
    @(negedge udp_clk);
    rx_valid = 1'b0;
    rx_sop   = 1'b0;
    rx_eop   = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] len);
    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0);
    send_byte(len[15:8], 1'b0, 1'b0);
    send_byte(len[7:0], 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge udp_clk);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rstn     = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rx_sop   = 1'b0;
    rx_eop   = 1'b0;

    // reset values
    #12;
    chk("rst_rx_ready",   64'(rx_ready),   64'd1);
    chk("rst_rec_en",     64'(rec_en),     64'd0);
    chk("rst_rec_data",   64'(rec_data),   64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_err",        64'(err_flags),  64'd0);
    chk("rst_state",      64'(dbg_state),  64'(ST_IDLE));
    @(negedge udp_clk);
    rstn = 1'b1;
    idle(2);

    // nominal LEN=2
    send_hdr(16'd2);
    send_byte(8'h11, 0, 0); send_byte(8'h22, 0, 0);
    send_byte(8'h33, 0, 0); send_byte(8'h44, 0, 0);
    send_byte(8'h55, 0, 0); send_byte(8'h66, 0, 0);
    send_byte(8'h77, 0, 0); send_byte(8'h88, 0, 1);
    idle(4);
    expect_word("nom_w0", 32'h11223344, 1'b0, 1'b1);
    expect_word("nom_w1", 32'h55667788, 1'b1, 1'b1);
    chk("nom_extra",  64'(obs_q.size()), 64'd0);
    chk("nom_err",    64'(err_flags),    64'd0);
    chk("nom_state",  64'(dbg_state),    64'(ST_IDLE));

    // bad magic low byte, then a good LEN=1 frame
    send_byte(8'hA5, 1, 0); send_byte(8'h00, 0, 0);
    send_byte(8'h12, 0, 0); send_byte(8'h34, 0, 1);
    idle(3);
    chk("badhdr_words", 64'(obs_q.size()), 64'd0);
    chk("badhdr_err",   64'(err_flags),    64'd0);
    chk("badhdr_state", 64'(dbg_state),    64'(ST_IDLE));
    send_hdr(16'd1);
    send_byte(8'hDE, 0, 0); send_byte(8'hAD, 0, 0);
    send_byte(8'hBE, 0, 0); send_byte(8'hEF, 0, 1);
    idle(3);
    expect_word("after_bad_w0", 32'hDEADBEEF, 1'b1, 1'b1);
    chk("after_bad_extra", 64'(obs_q.size()), 64'd0);

    // short frame LEN=3 with 5 payload bytes -> data, partial, one pad
    send_hdr(16'd3);
    send_byte(8'hAA, 0, 0); send_byte(8'hBB, 0, 0);
    send_byte(8'hCC, 0, 0); send_byte(8'hDD, 0, 0);
    send_byte(8'hEE, 0, 1);
    chk("short_pad_ready", 64'(rx_ready), 64'd0);
    idle(4);
    expect_word("short_w0", 32'hAABBCCDD, 1'b0, 1'b1);
    expect_word("short_w1", 32'hEE000000, 1'b0, 1'b0);
    expect_word("short_w2", 32'h00000000, 1'b1, 1'b0);
    chk("short_extra", 64'(obs_q.size()), 64'd0);
    chk("short_err",   64'(err_flags),    64'h2);
    chk("short_ready", 64'(rx_ready),     64'd1);

    // LEN=2049 -> len_err, dropped until eop
    send_hdr(16'h0801);
    chk("len_state_drop", 64'(dbg_state), 64'(ST_DROP));
    send_byte(8'h00, 0, 0); send_byte(8'h01, 0, 1);
    idle(3);
    chk("len_words", 64'(obs_q.size()), 64'd0);
    chk("len_err",   64'(err_flags),    64'h6);
    chk("len_state", 64'(dbg_state),    64'(ST_IDLE));

    // long frame LEN=1 with 6 bytes
    send_hdr(16'd1);
    send_byte(8'h01, 0, 0); send_byte(8'h02, 0, 0);
    send_byte(8'h03, 0, 0); send_byte(8'h04, 0, 0);
    send_byte(8'h05, 0, 0); send_byte(8'h06, 0, 1);
    idle(3);
    expect_word("long_w0", 32'h01020304, 1'b1, 1'b1);
    chk("long_extra", 64'(obs_q.size()), 64'd0);
    chk("long_err",   64'(err_flags),    64'h7);
    chk("long_state", 64'(dbg_state),    64'(ST_IDLE));

    // reset after two payload bytes
    send_hdr(16'd1);
    send_byte(8'h11, 0, 0); send_byte(8'h22, 0, 0);
    chk("pre_rst_state", 64'(dbg_state), 64'(ST_PAYLOAD));
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_rx_ready",   64'(rx_ready),   64'd1);
    chk("midrst_rec_en",     64'(rec_en),     64'd0);
    chk("midrst_rec_data",   64'(rec_data),   64'd0);
    chk("midrst_frame_done", 64'(frame_done), 64'd0);
    chk("midrst_err",        64'(err_flags),  64'd0);
    chk("midrst_state",      64'(dbg_state),  64'(ST_IDLE));
    @(negedge udp_clk);
    rstn = 1'b1;
    idle(1);
    send_hdr(16'd1);
    send_byte(8'hCA, 0, 0); send_byte(8'hFE, 0, 0);
    send_byte(8'hBA, 0, 0); send_byte(8'hBE, 0, 1);
    idle(3);
    expect_word("postrst_w0", 32'hCAFEBABE, 1'b1, 1'b1);
    chk("postrst_extra", 64'(obs_q.size()), 64'd0);
    chk("postrst_err",   64'(err_flags),    64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
